// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: two-requester front end for a shared serial 1100/0011
// detector. A granted 4-bit word is latched, the detector is cleared for
// CLR_CYC cycles, the word is shifted out MSB first, and the detector's
// Mealy output on the last bit is returned as a one-cycle result.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req0_valid/word/ready requester 0 handshake (acceptance = valid && ready)
//   req1_valid/word/ready requester 1 handshake
//   det_rst_n, det_in     drive the shared detector
//   det_dec               detector output, combinational on det_in
//   res_valid/id/match    one-cycle result pulse; id/match hold otherwise
//
// Build option: define SEQ_ARB_RR_EN for round-robin tie-breaking;
// otherwise requester 0 has fixed priority.
module seq_det_arbiter #(
  parameter int unsigned CLR_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_word,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_word,
  output logic       req1_ready,
  output logic       det_rst_n,
  output logic       det_in,
  input  logic       det_dec,
  output logic       res_valid,
  output logic       res_id,
  output logic       res_match
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [1:0] CLR_LAST = 2'(CLR_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt_q, cnt_nxt;
  logic [3:0] word_q;
  logic       id_q;
  logic       id_res_q;
  logic       match_q;
  logic       grant;
  logic       accept;

`ifdef SEQ_ARB_RR_EN
  logic last_q;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = ~last_q;
    else if (req1_valid)
      grant = 1'b1;
  end
`else
  always_comb begin
    grant = 1'b0;
    if (!req0_valid && req1_valid)
      grant = 1'b1;
  end
`endif

  assign accept = rst_n && (state == IDLE) && (req0_valid || req1_valid);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt = CLR;
          cnt_nxt   = '0;
        end
      end
      CLR: begin
        if (cnt_q == CLR_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 2'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == 2'd3) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      id_q     <= 1'b0;
      id_res_q <= 1'b0;
      match_q  <= 1'b0;
`ifdef SEQ_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (accept) begin
        word_q <= grant ? req1_word : req0_word;
        id_q   <= grant;
`ifdef SEQ_ARB_RR_EN
        last_q <= grant;
`endif
      end else if (state == SHIFT) begin
        // word_q shifts left so det_in is always word_q[3]
        word_q <= {word_q[2:0], 1'b0};
      end
      if (state == SHIFT && cnt_q == 2'd3) begin
        id_res_q <= id_q;
        match_q  <= det_dec;
      end
    end
  end

  // Outputs are gated by rst_n so they show reset values while reset is low,
  // before the synchronous reset edge has taken effect.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
  assign det_rst_n  = rst_n && (state != CLR);
  assign det_in     = rst_n && (state == SHIFT) && word_q[3];
  assign res_valid  = rst_n && (state == DONE);
  assign res_id     = rst_n && id_res_q;
  assign res_match  = rst_n && match_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: a behavioural 1100/0011 Mealy detector, a
// cycle-timing model of the arbiter, and a scoreboard of expected results.
module tb_seq_det_arbiter;

  localparam int CLR = 1;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_word, req1_word;
  logic       req0_ready, req1_ready;
  logic       det_rst_n, det_in, det_dec;
  logic       res_valid, res_id, res_match;

  seq_det_arbiter #(.CLR_CYC(CLR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_word  (req0_word),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_word  (req1_word),
    .req1_ready (req1_ready),
    .det_rst_n  (det_rst_n),
    .det_in     (det_in),
    .det_dec    (det_dec),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_match  (res_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared detector: 3 bits of history plus the live input
  logic [2:0] dhist;
  always @(posedge clk) begin
    if (!det_rst_n) dhist <= '0;
    else            dhist <= {dhist[1:0], det_in};
  end
  assign det_dec = ({dhist, det_in} == 4'b1100) || ({dhist, det_in} == 4'b0011);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_pat(input logic [3:0] w);
    return (w == 4'b0011) || (w == 4'b1100);
  endfunction

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [1:0] sb[$];   // {id, match}

  logic       acc0_seen, acc1_seen;
  logic       m_busy;
  int         m_k;
  logic [3:0] m_word;
  logic       m_last;
  logic       prev_id, prev_match;

  // monitor: samples mid-cycle on the falling edge
  initial begin
    logic       g;
    logic [1:0] e;
    int         idx;
    acc0_seen = 1'b0;
    acc1_seen = 1'b0;
    m_busy    = 1'b0;
    m_k       = 0;
    m_word    = '0;
    m_last    = 1'b1;
    prev_id   = 1'b0;
    prev_match= 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ready0",   int'(req0_ready), 0);
        check("rst_ready1",   int'(req1_ready), 0);
        check("rst_res_valid",int'(res_valid),  0);
        check("rst_res_id",   int'(res_id),     0);
        check("rst_res_match",int'(res_match),  0);
        check("rst_det_in",   int'(det_in),     0);
        check("rst_det_rst_n",int'(det_rst_n),  0);
        m_busy = 1'b0; m_last = 1'b1; sb.delete();
        prev_id = 1'b0; prev_match = 1'b0;
        acc0_seen = 1'b0; acc1_seen = 1'b0;
      end else begin
        acc0_seen = req0_valid && req0_ready;
        acc1_seen = req1_valid && req1_ready;
        if (res_valid) begin
          if (sb.size() == 0) begin
            check("res_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            check("res_id",    int'(res_id),    int'(e[1]));
            check("res_match", int'(res_match), int'(e[0]));
          end
          prev_id = res_id; prev_match = res_match;
        end else begin
          check("hold_id",    int'(res_id),    int'(prev_id));
          check("hold_match", int'(res_match), int'(prev_match));
        end
        if (!m_busy) begin
          g = 1'b0;
`ifdef SEQ_ARB_RR_EN
          if (req0_valid && req1_valid) g = ~m_last;
          else if (req1_valid)          g = 1'b1;
`else
          if (!req0_valid && req1_valid) g = 1'b1;
`endif
          check("idle_ready0",    int'(req0_ready), int'(req0_valid && !g));
          check("idle_ready1",    int'(req1_ready), int'(req1_valid && g));
          check("idle_det_in",    int'(det_in),     0);
          check("idle_det_rst_n", int'(det_rst_n),  1);
          check("idle_res_valid", int'(res_valid),  0);
          if (req0_valid || req1_valid) begin
            m_busy = 1'b1;
            m_k    = 0;
            m_word = g ? req1_word : req0_word;
            m_last = g;
            sb.push_back({g, is_pat(m_word)});
          end
        end else begin
          m_k++;
          check("busy_ready0", int'(req0_ready), 0);
          check("busy_ready1", int'(req1_ready), 0);
          if (m_k <= CLR) begin
            check("clr_det_rst_n", int'(det_rst_n), 0);
            check("clr_det_in",    int'(det_in),    0);
            check("clr_res_valid", int'(res_valid), 0);
          end else if (m_k <= CLR + 4) begin
            idx = 3 - (m_k - CLR - 1);
            check("shift_det_rst_n", int'(det_rst_n), 1);
            check("shift_det_in",    int'(det_in),    int'(m_word[idx]));
            check("shift_res_valid", int'(res_valid), 0);
          end else begin
            check("done_res_valid", int'(res_valid), 1);
            check("done_det_in",    int'(det_in),    0);
            check("done_det_rst_n", int'(det_rst_n), 1);
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0_seen && q0.size() != 0) void'(q0.pop_front());
    if (acc1_seen && q1.size() != 0) void'(q1.pop_front());
    req0_valid = (q0.size() != 0);
    req0_word  = (q0.size() != 0) ? q0[0] : 4'b0000;
    req1_valid = (q1.size() != 0);
    req1_word  = (q1.size() != 0) ? q1[0] : 4'b0000;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    step();
    while ((q0.size() != 0 || q1.size() != 0 || m_busy || sb.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check({tag, "_timeout"}, 1, 0);
    step();
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_word = '0;
    req1_valid = 1'b0; req1_word = '0;
    repeat (3) step();
    rst_n = 1'b1;

    q0.push_back(4'b1100);
    drain("req0_1100");

    q1.push_back(4'b0101);
    drain("req1_0101");

    for (int i = 0; i < 2; i++) begin
      q0.push_back(4'b0011);
      q1.push_back(4'b1010);
    end
    drain("both_valid");

    q0.push_back(4'b0011);
    n = 0;
    while (!(m_busy && m_k == CLR + 1) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("midshift_timeout", 1, 0);
    rst_n = 1'b0;
    q0.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    q0.push_back(4'b1100);
    drain("after_reset");

    for (int w = 0; w < 16; w++) q0.push_back(4'(w));
    drain("all_words");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/seq_det_arbiter.md
SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 SHALL have parameter: CLR_CYC, 1, number of cycles det_rst_n is held low before each word (1..3).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a word.
REQ-005 SHALL have port: req0_word  input  4  requester 0 word, MSB shifted first.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have port: req1_valid  input  1  requester 1 has a word.
REQ-008 SHALL have port: req1_word  input  4  requester 1 word.
REQ-009 SHALL have port: req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 SHALL have port: det_rst_n  output  1  drives shared detector rst_n.
REQ-011 SHALL have port: det_in  output  1  drives shared detector serial input.
REQ-012 SHALL have port: det_dec  input  1  Mealy detector output (combinational on det_in).
REQ-013 SHALL have port: res_valid  output  1  one-cycle result pulse.
REQ-014 SHALL have port: res_id  output  1  requester owning the result.
REQ-015 SHALL have port: res_match  output  1  detector reported 1100/0011 for the word.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, SHIFT, DONE.
REQ-017 IDLE: reqN_ready = 1 combinationally for the granted requester only, when its valid is high; acceptance = valid && ready.
REQ-018 On acceptance SHALL latch word and id; later changes to reqN_word have no effect; next state CLR.
REQ-019 CLR: det_rst_n = 0, det_in = 0 for CLR_CYC cycles, then SHIFT.
REQ-020 SHIFT: 4 cycles, det_in = word[3], word[2], word[1], word[0] in order; det_rst_n = 1.
REQ-021 SHALL sample det_dec at the clock edge ending the word[0] cycle into res_match; det_dec in earlier SHIFT cycles ignored.
REQ-022 DONE: res_valid = 1 for exactly one cycle with res_id, res_match; next state IDLE; no backpressure.
REQ-023 Latency: acceptance edge T -> res_valid high in cycle T+CLR_CYC+5 (T+6 for CLR_CYC=1).
REQ-024 Outside SHIFT det_in SHALL be 0; outside CLR and reset det_rst_n SHALL be 1.
REQ-025 ready SHALL be 0 in CLR, SHIFT, DONE; a new word is accepted no earlier than the IDLE cycle after DONE.
REQ-026 res_id, res_match SHALL hold their last values while res_valid = 0.
REQ-027 Only one requester valid: it SHALL be granted regardless of arbitration pointer.

Reset
REQ-028 rst_n = 0 at any edge, including mid-SHIFT, SHALL force IDLE, discard the in-flight word, and emit no result.
REQ-029 During reset: req0_ready = req1_ready = 0, res_valid = 0, res_id = 0, res_match = 0, det_in = 0, det_rst_n = 0.
REQ-030 Reset SHALL set the round-robin pointer so requester 0 wins the first tie.

Configuration
REQ-031 Macro SEQ_ARB_RR_EN defined: on both valid in IDLE, grant the requester not granted last (round-robin); pointer updates on every acceptance.
REQ-032 SEQ_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer state.

Verification
REQ-033 req0 word 1100 alone -> det_in 1,1,0,0 after one det_rst_n-low cycle; res_valid at T+6, res_id=0, res_match=1.
REQ-034 req1 word 0101 alone -> res_id=1, res_match=0; det_in=0 in IDLE/CLR/DONE.
REQ-035 Both valid continuously, words 0011/1010, SEQ_ARB_RR_EN -> results alternate id 0,1,0,1 with match 1,0,1,0; without macro -> id 0 every time.
REQ-036 rst_n low during second SHIFT cycle of 0011 -> no res_valid; all outputs at reset values; next word processed normally.
REQ-037 All 16 words from req0 back-to-back -> res_match=1 exactly for 0011 and 1100; one result every 7 cycles.
REQ-038 req0_word changed to 0000 the cycle after accepting 1100 -> res_match still 1.
